fma_arb_ctrl: RTL

FMA_ARB_CTRL -- requirements
Module: fma_arb_ctrl

---
 rtl/fma_ctrl_pkg.sv | 15 +
 rtl/rr_arb2.sv | 19 +
 rtl/fma_arb_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fma_ctrl_pkg.sv
// Shared types and constants for the FMA arbiter/controller.
package fma_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FP_W       = 32;
    localparam int OPND_W     = 128;
    localparam int DP_LAT_DEF = 2;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; i_last names the requester granted last.
module rr_arb2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        priority case (1'b1)
            i_valid0 && i_valid1: o_grant = i_last ? 2'b01 : 2'b10;
            i_valid0:             o_grant = 2'b01;
            i_valid1:             o_grant = 2'b10;
            default:              o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/fma_arb_ctrl.sv
// Arbitrates two requesters onto one multi-cycle FMA datapath
// and returns each result through a valid/ready response port.
module fma_arb_ctrl
    import fma_ctrl_pkg::*;
#(
    parameter int DP_LAT = DP_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [OPND_W-1:0] req0_opnd,
    input  logic [OPND_W-1:0] req1_opnd,
    input  logic              req0_op,
    input  logic              req1_op,
    input  logic [1:0]        req0_rnd,
    input  logic [1:0]        req1_rnd,
    output logic [FP_W-1:0]   dp_a,
    output logic [FP_W-1:0]   dp_b,
    output logic [FP_W-1:0]   dp_c,
    output logic [FP_W-1:0]   dp_d,
    output logic              dp_op,
    output logic [1:0]        dp_rnd,
    input  logic [FP_W-1:0]   dp_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FP_W-1:0]   rsp_data,
    output logic              rsp_id
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DP_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic               r_id;
    logic [1:0]         w_grant;
    logic [1:0]         w_rdy;
    logic               w_accept;
    logic               w_id;
    logic [OPND_W-1:0]  w_opnd;
    logic [FP_W-1:0]    r_a;
    logic [FP_W-1:0]    r_b;
    logic [FP_W-1:0]    r_c;
    logic [FP_W-1:0]    r_d;
    logic               r_op;
    logic [1:0]         r_rnd;
    logic               r_rsp_valid;
    logic [FP_W-1:0]    r_rsp_data;
    logic               r_rsp_id;

    rr_arb2 u_arb (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_last   (r_last),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 2'b00;
        unique case (r_state)
            IDLE: begin
                // Gate with rst so nothing is offered during reset.
                w_rdy = rst ? 2'b00 : w_grant;
                if (w_rdy != 2'b00) w_state_nxt = EXEC;
            end
            EXEC: if (r_cnt == '0) w_state_nxt = RESP;
            RESP: if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = |w_rdy;
    assign w_id     = w_rdy[1];
    assign w_opnd   = w_id ? req1_opnd : req0_opnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_op        <= 1'b0;
            r_rnd       <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_accept) begin
                r_last <= w_id;
                r_id   <= w_id;
                r_cnt  <= CNT_INIT;
                r_a    <= w_opnd[OPND_W-1 -: FP_W];
                r_b    <= w_opnd[OPND_W-FP_W-1 -: FP_W];
                r_c    <= w_opnd[OPND_W-2*FP_W-1 -: FP_W];
                r_d    <= w_opnd[FP_W-1:0];
                r_op   <= w_id ? req1_op : req0_op;
                r_rnd  <= w_id ? req1_rnd : req0_rnd;
            end else if (r_state == EXEC) begin
                if (r_cnt == '0) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= dp_out;
                    r_rsp_id    <= r_id;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end else if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req0_ready = w_rdy[0];
    assign req1_ready = w_rdy[1];
    assign dp_a       = r_a;
    assign dp_b       = r_b;
    assign dp_c       = r_c;
    assign dp_d       = r_d;
    assign dp_op      = r_op;
    assign dp_rnd     = r_rnd;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;

endmodule
